rs_mult: RTL and testbench



---
 rtl/rs_mult.sv | 236 +++++++++++++++++++++++
 tb/tb_rs_mult.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_mult.sv
// rs_mult: reservation station for the sequential multiply FU (dispatch, CDB wakeup, single issue).
// Optional feature macro: RS_MULT_WAKE_BYPASS_EN (same-cycle CDB wakeup feeds select and mult_pkt directly).

package rs_mult_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
    localparam int XLEN      = 32;

    typedef enum logic [1:0] {
        mul_op   = 2'd0,
        mulh_op  = 2'd1,
        mulsu_op = 2'd2,
        mulu_op  = 2'd3
    } mult_op_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
    } rvfi_t;

    typedef struct packed {
        mult_op_t             op;
        logic [ROB_TAG_W-1:0] rob_tag;
        rvfi_t                rvfi;
        logic [XLEN-1:0]      rs1_v;
        logic [XLEN-1:0]      rs2_v;
    } fu_pkt_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      data;
    } cdb_t;
endpackage

module rs_mult
    import rs_mult_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CDB_PORTS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall,
    input  logic                   disp_valid,
    input  fu_pkt_t                disp_pkt,
    input  logic                   disp_rs1_rdy,
    input  logic                   disp_rs2_rdy,
    input  logic [ROB_TAG_W-1:0]   disp_rs1_tag,
    input  logic [ROB_TAG_W-1:0]   disp_rs2_tag,
    input  cdb_t                   cdb [CDB_PORTS],
    input  logic                   mult_busy,
    output logic                   mult_en,
    output fu_pkt_t                mult_pkt,
    output logic                   rs_full,
    output logic [$clog2(DEPTH):0] rs_count
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = IDX_W + 1;
    // Snoop slots: two per entry (rs1, rs2) followed by the two dispatch operands.
    localparam int NSNOOP  = 2 * (DEPTH + 1);
    localparam int DISP_S1 = 2 * DEPTH;
    localparam int DISP_S2 = 2 * DEPTH + 1;

    logic                 valid_reg   [DEPTH];
    logic                 rs1_rdy_reg [DEPTH];
    logic                 rs2_rdy_reg [DEPTH];
    logic [ROB_TAG_W-1:0] rs1_tag_reg [DEPTH];
    logic [ROB_TAG_W-1:0] rs2_tag_reg [DEPTH];
    fu_pkt_t              pkt_reg     [DEPTH];
    logic                 issued_reg;
    logic [CNT_W-1:0]     count_reg;

    logic [ROB_TAG_W-1:0] snoop_tag  [NSNOOP];
    logic                 snoop_hit  [NSNOOP];
    logic [XLEN-1:0]      snoop_data [NSNOOP];

    logic                 entry_ready [DEPTH];
    logic [IDX_W-1:0]     alloc_idx;
    logic [IDX_W-1:0]     sel_idx;
    logic                 cand_found;
    fu_pkt_t              sel_pkt;
    logic                 alloc_en;
    logic                 issue_en;
    fu_pkt_t              disp_cap;
    logic                 disp_rs1_now;
    logic                 disp_rs2_now;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snoop_tag[2*i]   = rs1_tag_reg[i];
            snoop_tag[2*i+1] = rs2_tag_reg[i];
        end
        snoop_tag[DISP_S1] = disp_rs1_tag;
        snoop_tag[DISP_S2] = disp_rs2_tag;
    end

    // CDB match per operand slot; scanning high to low lets the lowest port index win.
    genvar gi;
    for (gi = 0; gi < NSNOOP; gi++) begin : g_snoop
        always_comb begin
            snoop_hit[gi]  = 1'b0;
            snoop_data[gi] = '0;
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (cdb[p].valid && (cdb[p].rob_tag == snoop_tag[gi])) begin
                    snoop_hit[gi]  = 1'b1;
                    snoop_data[gi] = cdb[p].data;
                end
            end
        end
    end

    // Free-slot search and full flag look only at registered valid bits.
    always_comb begin
        alloc_idx = '0;
        rs_full   = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                alloc_idx = IDX_W'(i);
                rs_full   = 1'b0;
            end
        end
    end

    always_comb begin
        disp_cap     = disp_pkt;
        disp_rs1_now = disp_rs1_rdy;
        disp_rs2_now = disp_rs2_rdy;
        if (!disp_rs1_rdy && snoop_hit[DISP_S1]) begin
            disp_rs1_now   = 1'b1;
            disp_cap.rs1_v = snoop_data[DISP_S1];
        end
        if (!disp_rs2_rdy && snoop_hit[DISP_S2]) begin
            disp_rs2_now   = 1'b1;
            disp_cap.rs2_v = snoop_data[DISP_S2];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_MULT_WAKE_BYPASS_EN
            entry_ready[i] = valid_reg[i]
                           && (rs1_rdy_reg[i] || snoop_hit[2*i])
                           && (rs2_rdy_reg[i] || snoop_hit[2*i+1]);
`else
            entry_ready[i] = valid_reg[i] && rs1_rdy_reg[i] && rs2_rdy_reg[i];
`endif
        end
    end

    always_comb begin
        cand_found = 1'b0;
        sel_idx    = '0;
        sel_pkt    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_ready[i]) begin
                cand_found = 1'b1;
                sel_idx    = IDX_W'(i);
                sel_pkt    = pkt_reg[i];
`ifdef RS_MULT_WAKE_BYPASS_EN
                if (!rs1_rdy_reg[i]) sel_pkt.rs1_v = snoop_data[2*i];
                if (!rs2_rdy_reg[i]) sel_pkt.rs2_v = snoop_data[2*i+1];
`endif
            end
        end
    end

    // issued_reg masks the cycle before the FU's registered busy becomes visible.
    assign alloc_en = disp_valid && !rs_full && !rst && !flush;
    assign issue_en = cand_found && !mult_busy && !stall && !flush && !issued_reg && !rst;

    always_comb begin
        mult_en  = issue_en;
        mult_pkt = '0;
        if (issue_en) begin
            mult_pkt = sel_pkt;
        end
    end

    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic alloc_here;
        logic issue_here;
        assign alloc_here = alloc_en && (alloc_idx == IDX_W'(gi));
        assign issue_here = issue_en && (sel_idx == IDX_W'(gi));

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                valid_reg[gi]   <= 1'b0;
                rs1_rdy_reg[gi] <= 1'b0;
                rs2_rdy_reg[gi] <= 1'b0;
            end else if (alloc_here) begin
                valid_reg[gi]   <= 1'b1;
                rs1_rdy_reg[gi] <= disp_rs1_now;
                rs2_rdy_reg[gi] <= disp_rs2_now;
                rs1_tag_reg[gi] <= disp_rs1_tag;
                rs2_tag_reg[gi] <= disp_rs2_tag;
                pkt_reg[gi]     <= disp_cap;
            end else if (valid_reg[gi]) begin
                if (issue_here) begin
                    valid_reg[gi] <= 1'b0;
                end
                if (!rs1_rdy_reg[gi] && snoop_hit[2*gi]) begin
                    rs1_rdy_reg[gi]   <= 1'b1;
                    pkt_reg[gi].rs1_v <= snoop_data[2*gi];
                end
                if (!rs2_rdy_reg[gi] && snoop_hit[2*gi+1]) begin
                    rs2_rdy_reg[gi]   <= 1'b1;
                    pkt_reg[gi].rs2_v <= snoop_data[2*gi+1];
                end
            end
        end
    end

    // Count tracks the valid bits exactly, so it reads as their popcount.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg  <= '0;
            issued_reg <= 1'b0;
        end else begin
            count_reg  <= count_reg + CNT_W'(alloc_en) - CNT_W'(issue_en);
            issued_reg <= issue_en;
        end
    end

    assign rs_count = count_reg;

    always_ff @(posedge clk) begin
        if (!rst && !flush && disp_valid) begin
            assert (!rs_full)
            else $warning("rs_mult: dispatch dropped, station full");
        end
    end

endmodule

// File: tb/tb_rs_mult.sv
// Scoreboard testbench for rs_mult: dispatch pushes the expected issue packet, the monitor pops on mult_en.
module tb_rs_mult;
    import rs_mult_pkg::*;

    localparam int DEPTH     = 4;
    localparam int CDB_PORTS = 2;
`ifdef RS_MULT_WAKE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   stall;
    logic                   disp_valid;
    fu_pkt_t                disp_pkt;
    logic                   disp_rs1_rdy;
    logic                   disp_rs2_rdy;
    logic [ROB_TAG_W-1:0]   disp_rs1_tag;
    logic [ROB_TAG_W-1:0]   disp_rs2_tag;
    cdb_t                   cdb [CDB_PORTS];
    logic                   mult_busy;
    logic                   mult_en;
    fu_pkt_t                mult_pkt;
    logic                   rs_full;
    logic [$clog2(DEPTH):0] rs_count;

    int      n_vectors     = 0;
    int      n_miscompares = 0;
    fu_pkt_t exp_q [$];

    rs_mult #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .stall        (stall),
        .disp_valid   (disp_valid),
        .disp_pkt     (disp_pkt),
        .disp_rs1_rdy (disp_rs1_rdy),
        .disp_rs2_rdy (disp_rs2_rdy),
        .disp_rs1_tag (disp_rs1_tag),
        .disp_rs2_tag (disp_rs2_tag),
        .cdb          (cdb),
        .mult_busy    (mult_busy),
        .mult_en      (mult_en),
        .mult_pkt     (mult_pkt),
        .rs_full      (rs_full),
        .rs_count     (rs_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge and drop one-cycle pulses.
    task automatic next();
        @(posedge clk);
        #1;
        disp_valid = 1'b0;
        flush      = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) cdb[p] = '0;
    endtask

    task automatic send(input mult_op_t op, input int tag,
                        input bit r1rdy, input int r1tag, input logic [31:0] v1,
                        input bit r2rdy, input int r2tag, input logic [31:0] v2,
                        input bit push);
        fu_pkt_t p;
        p.op        = op;
        p.rob_tag   = ROB_TAG_W'(tag);
        p.rvfi.pc   = 32'h1000 + 32'(tag) * 4;
        p.rvfi.insn = 32'h0200_0033 | (32'(tag) << 7);
        p.rs1_v     = v1;
        p.rs2_v     = v2;
        if (push) exp_q.push_back(p);
        disp_pkt = p;
        if (!r1rdy) disp_pkt.rs1_v = $urandom;
        if (!r2rdy) disp_pkt.rs2_v = $urandom;
        disp_rs1_rdy = r1rdy;
        disp_rs2_rdy = r2rdy;
        disp_rs1_tag = ROB_TAG_W'(r1tag);
        disp_rs2_tag = ROB_TAG_W'(r2tag);
        disp_valid   = 1'b1;
        $display("dispatch tag=%0d op=%0d rs1_rdy=%0b rs2_rdy=%0b expect_issue=%0b",
                 tag, op, r1rdy, r2rdy, push);
    endtask

    task automatic bcast(input int port, input int tag, input logic [31:0] d);
        cdb[port].valid   = 1'b1;
        cdb[port].rob_tag = ROB_TAG_W'(tag);
        cdb[port].data    = d;
    endtask

    // Release busy, wait (bounded) for one issue, then model the FU going busy.
    task automatic drain(input int n);
        bit got;
        for (int k = 0; k < n; k++) begin
            next();
            mult_busy = 1'b0;
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                @(negedge clk);
                if (mult_en) got = 1'b1;
                else next();
            end
            check("drain_issue", 64'(got), 64'd1);
            next();
            mult_busy = 1'b1;
            @(negedge clk);
            check("drain_gap", 64'(mult_en), 64'd0);
        end
    endtask

    // Scoreboard monitor: every issue must match the oldest outstanding expectation.
    initial begin
        fu_pkt_t e;
        forever begin
            @(negedge clk);
            if (mult_en === 1'b1) begin
                $display("issue tag=%0d op=%0d rs1_v=0x%08h rs2_v=0x%08h",
                         mult_pkt.rob_tag, mult_pkt.op, mult_pkt.rs1_v, mult_pkt.rs2_v);
                if (exp_q.size() == 0) begin
                    check("spurious_issue", 64'(mult_en), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_tag",  64'(mult_pkt.rob_tag), 64'(e.rob_tag));
                    check("issue_op",   64'(mult_pkt.op),      64'(e.op));
                    check("issue_pc",   64'(mult_pkt.rvfi.pc), 64'(e.rvfi.pc));
                    check("issue_rs1",  64'(mult_pkt.rs1_v),   64'(e.rs1_v));
                    check("issue_rs2",  64'(mult_pkt.rs2_v),   64'(e.rs2_v));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; mult_busy = 1'b0;
        disp_valid = 1'b0; disp_pkt = '0;
        disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_tag = '0; disp_rs2_tag = '0;
        for (int p = 0; p < CDB_PORTS; p++) cdb[p] = '0;

        // Reset state
        next();
        @(negedge clk);
        check("rst_mult_en",  64'(mult_en),   64'd0);
        check("rst_mult_pkt", 64'(|mult_pkt), 64'd0);
        check("rst_full",     64'(rs_full),   64'd0);
        check("rst_count",    64'(rs_count),  64'd0);

        // Both operands ready: issue the cycle after dispatch, count 0->1->0
        next(); rst = 1'b0;
        send(mul_op, 1, 1, 0, 32'd7, 1, 0, 32'd6, 1);
        @(negedge clk);
        check("t1_en_disp", 64'(mult_en), 64'd0);
        check("t1_cnt0",    64'(rs_count), 64'd0);
        next(); @(negedge clk);
        check("t1_en_issue", 64'(mult_en), 64'd1);
        check("t1_cnt1",     64'(rs_count), 64'd1);
        next(); @(negedge clk);
        check("t1_en_after", 64'(mult_en), 64'd0);
        check("t1_cnt2",     64'(rs_count), 64'd0);

        // rs2 waits on tag 5, woken by CDB port 1
        next();
        send(mulu_op, 2, 1, 0, 32'd3, 0, 5, 32'hFFFF_FFFF, 1);
        @(negedge clk); check("t2_en_disp", 64'(mult_en), 64'd0);
        next(); @(negedge clk);
        check("t2_en_wait", 64'(mult_en), 64'd0);
        check("t2_cnt",     64'(rs_count), 64'd1);
        next();
        bcast(0, 7, 32'h0BAD_0BAD);
        bcast(1, 5, 32'hFFFF_FFFF);
        @(negedge clk); check("t2_en_wake", 64'(mult_en), 64'(BYPASS));
        next(); @(negedge clk); check("t2_en_wake1", 64'(mult_en), 64'(!BYPASS));
        next(); @(negedge clk);
        check("t2_en_done", 64'(mult_en), 64'd0);
        check("t2_cnt_done", 64'(rs_count), 64'd0);

        // Dispatch-cycle snoop of rs1 tag 3; port 0 wins over port 1
        next();
        send(mul_op, 9, 0, 3, 32'h11, 1, 0, 32'h5, 1);
        bcast(0, 3, 32'h11);
        bcast(1, 3, 32'h22);
        @(negedge clk); check("t4_en_disp", 64'(mult_en), 64'd0);
        next(); @(negedge clk); check("t4_en_issue", 64'(mult_en), 64'd1);
        next(); @(negedge clk); check("t4_en_after", 64'(mult_en), 64'd0);

        // Fill all entries while busy, drop a fifth dispatch, then drain in order
        next(); mult_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(mult_op_t'(i), 10 + i, 1, 0, 32'(100 + i), 1, 0, 32'(200 + i), 1);
            @(negedge clk); check("t3_fill_en", 64'(mult_en), 64'd0);
            next();
        end
        send(mul_op, 14, 1, 0, 32'd1, 1, 0, 32'd1, 0);
        @(negedge clk);
        check("t3_full",  64'(rs_full),  64'd1);
        check("t3_count", 64'(rs_count), 64'd4);
        next(); @(negedge clk);
        check("t3_count_drop", 64'(rs_count), 64'd4);
        check("t3_en_busy",    64'(mult_en),  64'd0);
        next(); mult_busy = 1'b0;
        @(negedge clk); check("t3_first_issue", 64'(mult_en), 64'd1);
        next(); mult_busy = 1'b1;
        @(negedge clk);
        check("t3_gap",       64'(mult_en),  64'd0);
        check("t3_count3",    64'(rs_count), 64'd3);
        check("t3_not_full",  64'(rs_full),  64'd0);
        drain(3);

        // One pulse per busy window; dispatch and issue in the same cycle
        next(); mult_busy = 1'b1;
        send(mul_op, 20, 1, 0, 32'd20, 1, 0, 32'd21, 1);
        @(negedge clk); next();
        send(mulh_op, 21, 1, 0, 32'hDEAD_BEEF, 1, 0, 32'h1234_5678, 1);
        @(negedge clk); next();
        @(negedge clk); check("t5_cnt2", 64'(rs_count), 64'd2);
        next(); mult_busy = 1'b0;
        send(mulsu_op, 22, 1, 0, 32'h8000_0000, 1, 0, 32'd2, 1);
        @(negedge clk); check("t5_issue", 64'(mult_en), 64'd1);
        next(); @(negedge clk);
        check("t5_no_second", 64'(mult_en),  64'd0);
        check("t5_cnt_same",  64'(rs_count), 64'd2);
        next(); mult_busy = 1'b1;
        @(negedge clk); check("t5_busy_a", 64'(mult_en), 64'd0);
        next(); @(negedge clk); check("t5_busy_b", 64'(mult_en), 64'd0);
        next(); mult_busy = 1'b0;
        @(negedge clk); check("t5_reissue", 64'(mult_en), 64'd1);
        next(); mult_busy = 1'b1;
        @(negedge clk);
        drain(1);
        next(); mult_busy = 1'b0;

        // Stall blocks issue only
        stall = 1'b1;
        send(mulu_op, 25, 1, 0, 32'd9, 1, 0, 32'd10, 1);
        @(negedge clk); check("t7_en_a", 64'(mult_en), 64'd0);
        next(); @(negedge clk); check("t7_en_b", 64'(mult_en), 64'd0);
        next(); @(negedge clk);
        check("t7_en_c", 64'(mult_en),  64'd0);
        check("t7_cnt",  64'(rs_count), 64'd1);
        next(); stall = 1'b0;
        @(negedge clk); check("t7_release", 64'(mult_en), 64'd1);
        next(); @(negedge clk); check("t7_after", 64'(mult_en), 64'd0);

        // Flush with three valid entries under stall: nothing may ever issue
        next(); stall = 1'b1;
        send(mul_op, 30, 1, 0, 32'd1, 1, 0, 32'd2, 0);
        @(negedge clk); next();
        send(mulh_op, 31, 0, 6, 32'd3, 1, 0, 32'd4, 0);
        @(negedge clk); next();
        send(mulu_op, 32, 1, 0, 32'd5, 1, 0, 32'd6, 0);
        bcast(0, 6, 32'd3);
        @(negedge clk); next();
        flush = 1'b1;
        send(mul_op, 33, 1, 0, 32'd7, 1, 0, 32'd8, 0);
        @(negedge clk);
        check("t6_flush_en",  64'(mult_en),  64'd0);
        check("t6_cnt_pre",   64'(rs_count), 64'd3);
        next(); stall = 1'b0;
        @(negedge clk);
        check("t6_cnt_post",  64'(rs_count), 64'd0);
        check("t6_full_post", 64'(rs_full),  64'd0);
        for (int i = 0; i < 5; i++) begin
            check("t6_no_issue", 64'(mult_en), 64'd0);
            next(); @(negedge clk);
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
